cordic_mag_arb: RTL and testbench
=================================

CORDIC_MAG_ARB -- requirements
Module: cordic_mag_arb

Interface
REQ-001 Parameter D_WIDTH, default 16, is the width of each signed operand and of the magnitude result.
REQ-002 Parameter NUM_REQ, default 4, is the number of requesters (1..16).
REQ-003 Parameter CORE_LAT, default 18, is the cycles from core_x/core_y sampled at a clk edge to the matching core_r being valid.
REQ-004 Parameter FIFO_DEPTH, default 32, is the result FIFO depth (power of 2, at least 2).
REQ-005 Derived ID_W = max(1, clog2(NUM_REQ)).
REQ-006 One clock; reset is asynchronous and active-low: clk input 1, the clock; rst_n input 1, asynchronous active-low reset.
REQ-007 req_valid input NUM_REQ: per-requester request valid.
REQ-008 req_ready output NUM_REQ: per-requester accept, at most one bit set.
REQ-009 req_x, req_y input NUM_REQ*D_WIDTH each: packed signed operands, requester i at bits [i*D_WIDTH +: D_WIDTH].
REQ-010 core_mode output 2, core_x output D_WIDTH, core_y output D_WIDTH: drive to the shared magnitude core.
REQ-011 core_r input D_WIDTH: core magnitude result.
REQ-012 res_valid output 1, res_ready input 1, res_id output ID_W, res_r output D_WIDTH: result stream.
REQ-013 busy output 1: set while any request is in flight or the FIFO is non-empty.

Function
REQ-014 A request transfers on the cycle where req_valid[i] and req_ready[i] are both high. Requesters shall not make req_valid depend on req_ready.
REQ-015 req_ready is combinational: a one-hot round-robin grant among asserted req_valid bits, gated by credit > 0.
REQ-016 Round-robin search starts at last-granted index + 1, wrapping modulo NUM_REQ. The last-granted pointer updates only on a transfer.
REQ-017 core_mode is constant 2'd0 (magnitude). core_x and core_y are registered: the granted operands on the cycle after a transfer, otherwise zero.
REQ-018 A tag delay line of CORE_LAT+1 stages carries {valid, id} from grant. When the final stage is valid, core_r and the id are written to the FIFO that cycle. Bubbles are never written.
REQ-019 Credit counter, reset to FIFO_DEPTH:
  - decrements on a transfer;
  - increments on a FIFO pop (res_valid & res_ready);
  - is unchanged when both occur in the same cycle.
REQ-020 FIFO overflow is impossible by construction. A credit of zero forces all req_ready low.
REQ-021 res_valid = FIFO non-empty. res_r and res_id come from the FIFO head and are held stable while res_valid & !res_ready.
REQ-022 Grant-to-result latency is CORE_LAT+3 cycles with an empty FIFO and res_ready high (1 cycle input register, CORE_LAT, 1 cycle FIFO write, head visible).
REQ-023 Sustained throughput is 1 request/cycle when FIFO_DEPTH >= CORE_LAT+3 and res_ready is held high.
REQ-024 Results are returned in grant order. No reordering per requester or globally.

Reset
REQ-025 On rst_n low, the following clear asynchronously:
  - req_ready 0, core_x/core_y 0, res_valid 0, res_id 0, res_r 0, busy 0;
  - tag line invalid, FIFO empty, credit FIFO_DEPTH, last-granted pointer NUM_REQ-1.
REQ-026 Reset mid-operation discards all in-flight and buffered results. Core outputs arriving after reset are ignored because their tags are invalid.

Configuration
REQ-027 Macro CORDIC_MAG_ARB_STATS_EN adds output ports stat_issue (16) and stat_stall (16):
  - stat_issue counts transfers;
  - stat_stall counts cycles with any req_valid high and credit zero;
  - both saturate at 16'hFFFF and reset to 0.
REQ-028 Without CORDIC_MAG_ARB_STATS_EN these ports and counters are absent, and all other behaviour is identical.

Structure
REQ-029 The shared package holds mode encodings (MODE_MAG = 2'd0), default CORE_LAT and the ID_W clog2 function.
REQ-030 A single sub-module, cordic_res_fifo (synchronous FIFO of {id, r}, DEPTH parameter), is instantiated once. Arbitration, credit and tag logic stay in the top.

Verification
REQ-031 Single requester 0 sends x=3, y=4 → one result, res_id=0, res_r=5 (±1 LSB), exactly CORE_LAT+3 cycles after the transfer.
REQ-032 All 4 requesters valid continuously → grants 0,1,2,3,0,… one per cycle, and res_id returns in the same sequence.
REQ-033 res_ready low, 40 requests offered, FIFO_DEPTH=32 → exactly 32 transfers, then req_ready stays 0. Raising res_ready resumes transfers one per pop, with no loss or duplication.
REQ-034 Pop and grant in the same cycle at credit=1 → credit stays 1 and the transfer completes.
REQ-035 rst_n pulsed low 5 cycles after 3 transfers → no res_valid ever appears for them, and busy=0 immediately.
REQ-036 With STATS_EN, 100 transfers plus 10 credit-stall cycles → stat_issue=100, stat_stall=10. Without STATS_EN the build elaborates with no stat ports.

Source files
------------

// File: rtl/cordic_mag_arb_pkg.sv
// Shared definitions for the cordic_mag_arb request arbiter and its result FIFO:
// core mode encodings, default core latency and the requester-id width helper.
package cordic_mag_arb_pkg;

  typedef enum logic [1:0] {
    MODE_MAG  = 2'd0,
    MODE_ROT  = 2'd1,
    MODE_ATAN = 2'd2,
    MODE_RSVD = 2'd3
  } core_mode_e;

  localparam int DEF_CORE_LAT = 18;

  // Id width: clog2 of the requester count, never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cordic_res_fifo.sv
// Synchronous result FIFO of {id, r} words with a registered head stage, so a
// written word becomes visible at the output one cycle after the write.
module cordic_res_fifo
  import cordic_mag_arb_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         not_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          load;

  // The head register refills whenever it is empty or being popped.
  assign load      = (cnt != '0) && (!out_valid || rd_en);
  assign not_empty = out_valid || (cnt != '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (rd_en) begin
        out_valid <= 1'b0;
      end
      if (wr_en && !load) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (!wr_en && load) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cordic_mag_arb.sv
// Round-robin arbiter feeding a shared magnitude core, with credit-based flow
// control into an in-order result FIFO. Optional counters: CORDIC_MAG_ARB_STATS_EN.
module cordic_mag_arb
  import cordic_mag_arb_pkg::*;
#(
  parameter  int D_WIDTH    = 16,
  parameter  int NUM_REQ    = 4,
  parameter  int CORE_LAT   = DEF_CORE_LAT,
  parameter  int FIFO_DEPTH = 32,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*D_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*D_WIDTH-1:0] req_y,
  output logic [1:0]                 core_mode,
  output logic [D_WIDTH-1:0]         core_x,
  output logic [D_WIDTH-1:0]         core_y,
  input  logic [D_WIDTH-1:0]         core_r,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [D_WIDTH-1:0]         res_r,
  output logic                       busy
`ifdef CORDIC_MAG_ARB_STATS_EN
  ,
  output logic [15:0]                stat_issue,
  output logic [15:0]                stat_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = ID_W + D_WIDTH;

  // Handshake: a request moves on the clk edge where req_valid[i] and
  // req_ready[i] are both high; req_valid must never wait on req_ready.
  // res_valid/res_ready follow the same rule, and the head is held until popped.

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  int                 arb_idx;
  logic [ID_W-1:0]    last_ptr;
  logic [CW-1:0]      credit;
  logic               credit_ok;
  logic               transfer;
  logic               pop;
  logic [D_WIDTH-1:0] sel_x;
  logic [D_WIDTH-1:0] sel_y;
  logic [CORE_LAT:0]  tag_v;
  logic [ID_W-1:0]    tag_id [CORE_LAT+1];
  logic               fifo_not_empty;
  logic [FW-1:0]      fifo_out;

  assign core_mode = MODE_MAG;

  // Rotating search: start one past the last granted requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    arb_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(last_ptr) + k) % NUM_REQ;
      if (!found && req_valid[arb_idx]) begin
        found          = 1'b1;
        grant[arb_idx] = 1'b1;
        grant_id       = ID_W'(arb_idx);
      end
    end
  end

  // Credits mirror free FIFO slots, so the FIFO can never overflow.
  assign credit_ok = (credit != '0);
  assign req_ready = (rst_n && credit_ok) ? grant : '0;
  assign transfer  = |req_ready;
  assign pop       = res_valid && res_ready;

  assign sel_x = req_x[grant_id*D_WIDTH +: D_WIDTH];
  assign sel_y = req_y[grant_id*D_WIDTH +: D_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x   <= '0;
      core_y   <= '0;
      last_ptr <= ID_W'(NUM_REQ - 1);
      credit   <= CW'(FIFO_DEPTH);
    end else begin
      core_x <= transfer ? sel_x : '0;
      core_y <= transfer ? sel_y : '0;
      if (transfer) last_ptr <= grant_id;
      if (transfer && !pop) begin
        credit <= credit - CW'(1);
      end else if (pop && !transfer) begin
        credit <= credit + CW'(1);
      end
    end
  end

  // Tag line tracks each grant through the core; the last stage lines up with core_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i <= CORE_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[CORE_LAT-1:0], transfer};
      tag_id[0] <= grant_id;
      for (int i = 1; i <= CORE_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  cordic_res_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (tag_v[CORE_LAT]),
    .wr_data   ({tag_id[CORE_LAT], core_r}),
    .rd_en     (pop),
    .out_valid (res_valid),
    .out_data  (fifo_out),
    .not_empty (fifo_not_empty)
  );

  assign res_id = fifo_out[FW-1 -: ID_W];
  assign res_r  = fifo_out[D_WIDTH-1:0];
  assign busy   = (|tag_v) || fifo_not_empty;

`ifdef CORDIC_MAG_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (transfer && stat_issue != 16'hFFFF) stat_issue <= stat_issue + 16'd1;
      if ((|req_valid) && !credit_ok && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_mag_arb.sv
// Directed bench for cordic_mag_arb with a behavioural magnitude core model
// and an in-order scoreboard of {id, magnitude} words.
module tb_cordic_mag_arb;

  localparam int D_W   = 16;
  localparam int N     = 4;
  localparam int LAT   = 18;
  localparam int DEPTH = 32;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*D_W-1:0] req_x;
  logic [N*D_W-1:0] req_y;
  logic [1:0]       core_mode;
  logic [D_W-1:0]   core_x;
  logic [D_W-1:0]   core_y;
  logic [D_W-1:0]   core_r;
  logic             res_valid;
  logic             res_ready;
  logic [ID_W-1:0]  res_id;
  logic [D_W-1:0]   res_r;
  logic             busy;
`ifdef CORDIC_MAG_ARB_STATS_EN
  logic [15:0]      stat_issue;
  logic [15:0]      stat_stall;
`endif

  int errors = 0;
  int checks = 0;
  logic [ID_W+D_W-1:0] exp_q[$];
  int grant_log[$];
  int xfer_total = 0;
  int pop_total  = 0;

  always #5 clk = ~clk;

  cordic_mag_arb #(
    .D_WIDTH    (D_W),
    .NUM_REQ    (N),
    .CORE_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .core_mode (core_mode),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_r    (core_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_r     (res_r),
    .busy      (busy)
`ifdef CORDIC_MAG_ARB_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  function automatic logic [D_W-1:0] mag(input logic [D_W-1:0] x, input logic [D_W-1:0] y);
    longint sx, sy, s, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = sx * sx + sy * sy;
    r  = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return D_W'(r);
  endfunction

  // Core model: a LAT-deep pipe; operands captured on the edge after the grant.
  logic [D_W-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= mag(core_x, core_y);
  end
  assign core_r = core_pipe[LAT-1];

  // Scoreboard: sampled mid-cycle, ahead of the edge where the handshakes occur.
  always @(negedge clk) begin
    logic [ID_W+D_W-1:0] exp;
    #2;
    if (rst_n) begin
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++;
        $display("FAIL ready_onehot: got req_ready=%b, required at most one bit", req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({ID_W'(i), mag(req_x[i*D_W +: D_W], req_y[i*D_W +: D_W])});
          grant_log.push_back(i);
          xfer_total++;
        end
      end
      if (res_valid && res_ready) begin
        pop_total++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got id=%0d r=%0d, required no result", res_id, res_r);
        end else begin
          exp = exp_q.pop_front();
          if ({res_id, res_r} !== exp) begin
            errors++;
            $display("FAIL sb_result: got id=%0d r=%0d, required id=%0d r=%0d",
                     res_id, res_r, exp[D_W +: ID_W], exp[D_W-1:0]);
          end
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    exp_q.delete();
    grant_log.delete();
    xfer_total = 0;
    pop_total  = 0;
    rst_n      = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    req_valid = '1;
    res_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== '0)   begin errors++; $display("FAIL rst_ready: got %b, required 0", req_ready); end
    checks++; if (core_x !== '0)      begin errors++; $display("FAIL rst_core_x: got %0d, required 0", core_x); end
    checks++; if (core_y !== '0)      begin errors++; $display("FAIL rst_core_y: got %0d, required 0", core_y); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
    checks++; if (res_id !== '0)      begin errors++; $display("FAIL rst_res_id: got %0d, required 0", res_id); end
    checks++; if (res_r !== '0)       begin errors++; $display("FAIL rst_res_r: got %0d, required 0", res_r); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (core_mode !== 2'd0) begin errors++; $display("FAIL core_mode: got %0d, required 0", core_mode); end
`ifdef CORDIC_MAG_ARB_STATS_EN
    checks++; if (stat_issue !== 16'd0) begin errors++; $display("FAIL rst_stat_issue: got %0d, required 0", stat_issue); end
    checks++; if (stat_stall !== 16'd0) begin errors++; $display("FAIL rst_stat_stall: got %0d, required 0", stat_stall); end
`endif
    @(negedge clk);
    @(negedge clk);
    checks++; if (core_x !== '0) begin errors++; $display("FAIL rst_hold_core_x: got %0d, required 0", core_x); end
    rst_n = 1'b1;
    #1;
    // Pointer resets to NUM_REQ-1, so requester 0 wins first.
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b, required 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single;
    int n;
    do_reset;
    res_ready = 1'b1;
    @(negedge clk);
    req_x[0 +: D_W] = 16'd3;
    req_y[0 +: D_W] = 16'd4;
    req_valid       = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, required 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != LAT + 3) begin errors++; $display("FAIL single_latency: got %0d cycles, required %0d", n, LAT + 3); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d, required 0", res_id); end
    checks++; if (res_r !== 16'd5) begin errors++; $display("FAIL single_r: got %0d, required 5", res_r); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_idle_busy: got %b, required 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b, required 0", res_valid); end
  endtask

  task automatic test_round_robin;
    int ox [N] = '{3, -5, 8, 7};
    int oy [N] = '{4, 12, -15, 24};
    int cyc;
    do_reset;
    res_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_x[i*D_W +: D_W] = D_W'(ox[i]);
      req_y[i*D_W +: D_W] = D_W'(oy[i]);
    end
    req_valid = '1;
    repeat (12) @(negedge clk);
    req_valid = '0;
    #3;
    checks++; if (grant_log.size() != 12) begin errors++; $display("FAIL rr_count: got %0d grants, required 12", grant_log.size()); end
    for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] != k % N) begin
        errors++;
        $display("FAIL rr_order: grant %0d got requester %0d, required %0d", k, grant_log[k], k % N);
      end
    end
    wait_idle(cyc);
    checks++; if (cyc >= 400) begin errors++; $display("FAIL rr_drain: got timeout, required idle"); end
    checks++; if (pop_total != 12) begin errors++; $display("FAIL rr_pops: got %0d, required 12", pop_total); end
  endtask

  task automatic test_backpressure;
    int sent;
    int cyc;
    logic rdy;
    do_reset;
    sent = 0;
    repeat (45) begin
      @(negedge clk);
      req_x[0 +: D_W] = D_W'(sent + 1);
      req_y[0 +: D_W] = '0;
      req_valid       = (sent < 40) ? 4'b0001 : 4'b0000;
      #1;
      if (req_ready[0]) sent++;
    end
    checks++; if (sent != DEPTH)     begin errors++; $display("FAIL bp_fill: got %0d transfers, required %0d", sent, DEPTH); end
    checks++; if (req_ready !== '0)  begin errors++; $display("FAIL bp_ready_low: got %b, required 0", req_ready); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid: got %b, required 1", res_valid); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      res_ready       = 1'b1;
      req_x[0 +: D_W] = D_W'(sent + 1);
      req_valid       = (sent < 40) ? 4'b0001 : 4'b0000;
      #1;
      rdy = req_ready[0];
      if (rdy) sent++;
      if (k == 0) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_first_pop_ready: got %b, required 0", rdy); end
      end
      // k==2: pop and grant shared the previous edge at credit 1.
      if (k == 1 || k == 2) begin
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_credit_one_k%0d: got %b, required 1", k, rdy); end
      end
    end
    req_valid = '0;
    checks++; if (sent != 40) begin errors++; $display("FAIL bp_total: got %0d transfers, required 40", sent); end
    wait_idle(cyc);
    checks++; if (cyc >= 400)      begin errors++; $display("FAIL bp_drain: got timeout, required idle"); end
    checks++; if (pop_total != 40) begin errors++; $display("FAIL bp_pops: got %0d, required 40", pop_total); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    do_reset;
    res_ready = 1'b1;
    @(negedge clk);
    req_x[0 +: D_W] = 16'd6;
    req_y[0 +: D_W] = 16'd8;
    req_valid       = 4'b0001;
    repeat (3) @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b, required 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy_reset: got %b, required 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_reset: got %b, required 0", res_valid); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_ghost_result: got activity, required none"); end
  endtask

`ifdef CORDIC_MAG_ARB_STATS_EN
  task automatic test_stats;
    int sent;
    int stalls;
    int cyc;
    do_reset;
    sent   = 0;
    stalls = 0;
    while (stalls < 10 && sent < 100) begin
      @(negedge clk);
      req_x[0 +: D_W] = D_W'(sent + 1);
      req_y[0 +: D_W] = '0;
      req_valid       = 4'b0001;
      #1;
      if (req_ready[0]) sent++;
      else stalls++;
    end
    @(negedge clk);
    req_valid = '0;
    res_ready = 1'b1;
    cyc = 0;
    while (sent < 100 && cyc < 500) begin
      @(negedge clk);
      req_x[0 +: D_W] = D_W'(sent + 1);
      req_valid       = 4'b0001;
      #1;
      if (req_ready[0]) sent++;
      cyc++;
    end
    @(negedge clk);
    req_valid = '0;
    checks++; if (stat_issue !== 16'd100) begin errors++; $display("FAIL stat_issue: got %0d, required 100", stat_issue); end
    checks++; if (stat_stall !== 16'd10)  begin errors++; $display("FAIL stat_stall: got %0d, required 10", stat_stall); end
    wait_idle(cyc);
    checks++; if (pop_total != 100) begin errors++; $display("FAIL stat_pops: got %0d, required 100", pop_total); end
  endtask
`endif

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    req_x     = '0;
    req_y     = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
`ifdef CORDIC_MAG_ARB_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
